// File: rtl/es8psk_rx_framer_if.sv
// Message and byte-stream bundle between the 8PSK decoder/host and the rx framer.
// Latency: none (wires only).
// Backpressure: out_ready from the consumer stalls the byte stream; the message side has none.
// Ports (signals):
//   data_8psk_rx[203:0], ena_data_rx, fail_data : decoded message and its strobe/fail flag
//   out_byte[7:0], out_valid, out_ready, out_first, out_last, out_fail : byte stream
// Modports: master = decoder/host environment, slave = framer.
interface es8psk_rx_framer_if;
  logic [203:0] data_8psk_rx;
  logic         ena_data_rx;
  logic         fail_data;
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_ready;
  logic         out_first;
  logic         out_last;
  logic         out_fail;

  modport master (
    output data_8psk_rx, ena_data_rx, fail_data, out_ready,
    input  out_byte, out_valid, out_first, out_last, out_fail
  );

  modport slave (
    input  data_8psk_rx, ena_data_rx, fail_data, out_ready,
    output out_byte, out_valid, out_first, out_last, out_fail
  );
endinterface

// File: rtl/es8psk_rx_framer.sv
// Buffers decoded 204-bit 8PSK messages in a message FIFO and streams each one out as 26 bytes.
// Latency: strobe at t -> fifo_level=1 at t+1 -> first byte valid at t+2; one dead cycle between messages.
// Backpressure: out_ready stalls the byte stream (outputs held); a full FIFO drops new messages and pulses overflow.
// Ports:
//   clk, reset         : decimated receiver clock, async active-high reset (release synchronised here)
//   bus (slave)        : message in (data_8psk_rx/ena_data_rx/fail_data), byte stream out
//   drop_failed        : discard messages flagged fail_data
//   overflow           : one-cycle pulse when a message is lost to a full FIFO
//   fifo_level         : messages waiting in the FIFO (output stage excluded)
//   cnt_good/fail/drop : statistics, live only when ES8PSK_RX_STATS_EN is defined, else tied to 0
module es8psk_rx_framer #(
  parameter int  DEPTH  = 4,
  parameter int  W_DATA = 204,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  es8psk_rx_framer_if.slave        bus,
  input  logic                     drop_failed,
  output logic                     overflow,
  output logic [LW-1:0]            fifo_level,
  output logic [15:0]              cnt_good,
  output logic [15:0]              cnt_fail,
  output logic [15:0]              cnt_drop
);

  localparam int              PW       = $clog2(DEPTH);
  localparam int              NBYTE    = 26;
  localparam logic [LW-1:0]   DEPTH_L  = LW'(DEPTH);
  localparam logic [4:0]      LAST_IDX = 5'(NBYTE - 1);

  generate
    if (W_DATA != 204) begin : g_bad_width
      $error("es8psk_rx_framer: W_DATA must be 204");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("es8psk_rx_framer: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst_int = rst_sync_q[1];

  typedef enum logic {IDLE, SEND} state_t;

  // ---------------- message FIFO: entry = {fail, data}
  logic [W_DATA:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q;
  logic            wr_req, wr_acc, pop;
  logic [W_DATA:0] head;
  state_t          state_q;

  assign pop    = (state_q == IDLE) && (level_q != '0);
  assign wr_req = bus.ena_data_rx && !(bus.fail_data && drop_failed);
  // A full FIFO still accepts when the output stage pops in the same cycle.
  assign wr_acc = wr_req && ((level_q < DEPTH_L) || pop);
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({wr_acc, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= {bus.fail_data, bus.data_8psk_rx};
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
      ovf_q   <= wr_req && !wr_acc;
    end
  end

  assign overflow   = ovf_q;
  assign fifo_level = level_q;

  // ---------------- output stage
  // sh_q holds {data, 4'b0}; the current byte is always its top 8 bits, so
  // shifting left by a byte per beat yields bytes 0..24 MSB first and then
  // {data[3:0], 4'b0000} as byte 25.
  logic [W_DATA+3:0] sh_q;
  logic [4:0]        idx_q;
  logic              vld_q, first_q, last_q, fail_q;

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            sh_q    <= {head[W_DATA-1:0], 4'b0000};
            fail_q  <= head[W_DATA];
            idx_q   <= '0;
            vld_q   <= 1'b1;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (idx_q == LAST_IDX) begin
              vld_q   <= 1'b0;
              first_q <= 1'b0;
              last_q  <= 1'b0;
              fail_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_q + 5'd1;
              sh_q    <= {sh_q[W_DATA-5:0], 8'h00};
              first_q <= 1'b0;
              last_q  <= (idx_q == LAST_IDX - 5'd1);
            end
          end
        end
      endcase
    end
  end

  assign bus.out_byte  = sh_q[W_DATA+3 -: 8];
  assign bus.out_valid = vld_q;
  assign bus.out_first = first_q;
  assign bus.out_last  = last_q;
  assign bus.out_fail  = fail_q;

  // ---------------- statistics
`ifdef ES8PSK_RX_STATS_EN
  logic [15:0] good_q, failc_q, drop_q;
  logic        good_inc, fail_inc, drop_inc;

  assign good_inc = wr_acc && !bus.fail_data;
  assign fail_inc = bus.ena_data_rx && bus.fail_data;
  // Both drop_failed discards and overflow losses count as drops.
  assign drop_inc = bus.ena_data_rx && !wr_acc;

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      good_q  <= '0;
      failc_q <= '0;
      drop_q  <= '0;
    end else begin
      if (good_inc && good_q  != 16'hFFFF) good_q  <= good_q  + 16'd1;
      if (fail_inc && failc_q != 16'hFFFF) failc_q <= failc_q + 16'd1;
      if (drop_inc && drop_q  != 16'hFFFF) drop_q  <= drop_q  + 16'd1;
    end
  end

  assign cnt_good = good_q;
  assign cnt_fail = failc_q;
  assign cnt_drop = drop_q;
`else
  assign cnt_good = 16'd0;
  assign cnt_fail = 16'd0;
  assign cnt_drop = 16'd0;
`endif

endmodule

// File: tb/tb_es8psk_rx_framer.sv
// Directed scenarios with random payloads and random consumer stalls, checked
// against a message-level reference (queue of expected messages plus
// arithmetic byte extraction).
module tb_es8psk_rx_framer;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

`ifdef ES8PSK_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          drop_failed;
  logic          overflow;
  logic [LW-1:0] fifo_level;
  logic [15:0]   cnt_good, cnt_fail, cnt_drop;

  es8psk_rx_framer_if bus ();

  es8psk_rx_framer #(.DEPTH(DEPTH), .W_DATA(204)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .drop_failed (drop_failed),
    .overflow    (overflow),
    .fifo_level  (fifo_level),
    .cnt_good    (cnt_good),
    .cnt_fail    (cnt_fail),
    .cnt_drop    (cnt_drop)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ovf_cnt  = 0;
  int exp_good = 0;
  int exp_fail = 0;
  int exp_drop = 0;
  logic [204:0] exp_q [$];

  always @(negedge clk) if (overflow === 1'b1) ovf_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed time=%0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [203:0] rand_data();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
    return t[203:0];
  endfunction

  // Byte k of a message: k<25 -> data[203-8k -: 8]; k=25 -> {data[3:0],4'b0}
  function automatic logic [7:0] exp_byte(input logic [203:0] d, input int k);
    logic [203:0] s;
    if (k < 25) s = d >> (196 - 8 * k);
    else        s = d << 4;
    return s[7:0];
  endfunction

  task automatic chk_stats(input string tag);
    chk({tag, "_cnt_good"}, 256'(cnt_good), STATS ? 256'(exp_good) : 256'(0));
    chk({tag, "_cnt_fail"}, 256'(cnt_fail), STATS ? 256'(exp_fail) : 256'(0));
    chk({tag, "_cnt_drop"}, 256'(cnt_drop), STATS ? 256'(exp_drop) : 256'(0));
  endtask

  // One-cycle strobe; 'fits' says whether the FIFO has room by the test's reasoning.
  task automatic send(input logic [203:0] d, input logic f, input bit fits);
    bit acc;
    bus.data_8psk_rx = d;
    bus.fail_data    = f;
    bus.ena_data_rx  = 1'b1;
    acc = fits && !(f && drop_failed);
    if (acc) exp_q.push_back({f, d});
    if (f) exp_fail++;
    if (acc && !f) exp_good++;
    if (!acc) exp_drop++;
    @(negedge clk);
    bus.ena_data_rx = 1'b0;
  endtask

  // Consume nmsg messages; rmode 0 = ready always 1, 1 = random ready.
  // Returns at the negedge whose beat completes the last message.
  task automatic drain(input int nmsg, input int rmode, input int budget, output int cycles);
    int k = 0;
    int done = 0;
    bit stall = 0;
    logic [11:0] held = '0;
    logic [204:0] m;
    cycles = 0;
    while (done < nmsg && cycles < budget) begin
      bus.out_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (stall)
        chk("stall_hold", 256'({bus.out_valid, bus.out_fail, bus.out_first, bus.out_last, bus.out_byte}),
            256'(held));
      stall = 0;
      if (bus.out_valid === 1'b1) begin
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_byte", 256'(exp_q.size()), 256'(1));
          end else begin
            m = exp_q[0];
            chk($sformatf("beat%0d", k),
                256'({bus.out_first, bus.out_last, bus.out_fail, bus.out_byte}),
                256'({k == 0, k == 25, m[204], exp_byte(m[203:0], k)}));
            k++;
            if (k == 26) begin
              k = 0;
              void'(exp_q.pop_front());
              done++;
            end
          end
        end else begin
          stall = 1;
          held = {bus.out_valid, bus.out_fail, bus.out_first, bus.out_last, bus.out_byte};
        end
      end
      cycles++;
      if (done < nmsg) @(negedge clk);
    end
    if (done < nmsg) chk("drain_timeout_msgs", 256'(done), 256'(nmsg));
  endtask

  initial begin
    logic [203:0] d1;
    logic [203:0] d;
    logic [204:0] m;
    int cyc;
    int ovf0;

    reset = 1'b1;
    drop_failed = 1'b0;
    bus.ena_data_rx = 1'b0;
    bus.fail_data = 1'b0;
    bus.data_8psk_rx = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // ---- reset state
    chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_out_flags", 256'({bus.out_byte, bus.out_first, bus.out_last, bus.out_fail}), 256'(0));
    chk("rst_overflow", 256'(overflow), 256'(0));
    chk("rst_level", 256'(fifo_level), 256'(0));
    chk_stats("rst");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_valid", 256'(bus.out_valid), 256'(0));

    // ---- 1: single message, ready=1, latency and byte map
    d1 = rand_data();
    d1[203:192] = 12'hABC;
    bus.out_ready = 1'b1;
    send(d1, 1'b0, 1);
    chk("t1_level_t1", 256'(fifo_level), 256'(1));
    chk("t1_valid_t1", 256'(bus.out_valid), 256'(0));
    chk_stats("t1");
    @(negedge clk);
    chk("t1_valid_t2", 256'(bus.out_valid), 256'(1));
    chk("t1_first_byte", 256'(bus.out_byte), 256'(8'hAB));
    chk("t1_level_t2", 256'(fifo_level), 256'(0));
    drain(1, 0, 100, cyc);
    chk("t1_cycles", 256'(cyc), 256'(26));
    @(negedge clk);
    chk("t1_dead_cycle", 256'(bus.out_valid), 256'(0));

    // ---- 2: same message, random ready
    send(d1, 1'b0, 1);
    drain(1, 1, 400, cyc);
    @(negedge clk);

    // ---- 3: ready=0, six back-to-back strobes: output stage + DEPTH slots fill
    bus.out_ready = 1'b0;
    ovf0 = ovf_cnt;
    for (int i = 0; i < 6; i++) send(rand_data(), 1'b0, i < DEPTH + 1);
    chk("t3_level_full", 256'(fifo_level), 256'(DEPTH));
    chk("t3_overflow_pulse", 256'(overflow), 256'(1));
    chk_stats("t3");
    repeat (2) @(negedge clk);
    chk("t3_overflow_count", 256'(ovf_cnt - ovf0), 256'(1));
    chk("t3_overflow_low", 256'(overflow), 256'(0));
    drain(DEPTH + 1, 1, 2000, cyc);
    @(negedge clk);
    chk("t3_empty", 256'(fifo_level), 256'(0));

    // ---- 4: failed message dropped, then kept
    drop_failed = 1'b1;
    send(rand_data(), 1'b1, 1);
    chk("t4_not_stored", 256'(fifo_level), 256'(0));
    chk("t4_no_overflow", 256'(overflow), 256'(0));
    chk_stats("t4a");
    repeat (3) @(negedge clk);
    chk("t4_no_output", 256'(bus.out_valid), 256'(0));
    drop_failed = 1'b0;
    send(rand_data(), 1'b1, 1);
    chk_stats("t4b");
    drain(1, 1, 400, cyc);
    @(negedge clk);

    // ---- 5: FIFO full, pop and strobe in the same cycle
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) send(rand_data(), 1'b0, 1);
    chk("t5_level_full", 256'(fifo_level), 256'(DEPTH));
    drain(1, 0, 100, cyc);
    @(negedge clk);
    chk("t5_idle_full", 256'({bus.out_valid, fifo_level}), 256'({1'b0, LW'(DEPTH)}));
    bus.out_ready = 1'b0;
    ovf0 = ovf_cnt;
    send(rand_data(), 1'b0, 1);
    chk("t5_level_same", 256'(fifo_level), 256'(DEPTH));
    chk("t5_no_overflow", 256'(overflow), 256'(0));
    chk("t5_popped", 256'(bus.out_valid), 256'(1));
    chk_stats("t5");
    drain(DEPTH + 1, 1, 2000, cyc);
    @(negedge clk);
    chk("t5_ovf_none", 256'(ovf_cnt - ovf0), 256'(0));

    // ---- 6: reset in the middle of a message
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_data(), 1'b0, 1);
    chk("t6_level", 256'(fifo_level), 256'(2));
    chk("t6_valid", 256'(bus.out_valid), 256'(1));
    bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);
    m = exp_q[0];
    chk("t6_byte10", 256'({bus.out_first, bus.out_byte}), 256'({1'b0, exp_byte(m[203:0], 10)}));
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 256'(bus.out_valid), 256'(0));
    chk("t6_rst_level", 256'(fifo_level), 256'(0));
    exp_q.delete();
    exp_good = 0;
    exp_fail = 0;
    exp_drop = 0;
    chk_stats("t6_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_after_valid", 256'(bus.out_valid), 256'(0));
    d = rand_data();
    send(d, 1'b0, 1);
    chk("t6_after_level", 256'(fifo_level), 256'(1));
    drain(1, 1, 400, cyc);
    @(negedge clk);
    chk_stats("t6_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
